// File: rtl/slot_reel_engine.sv
// rtl/slot_reel_engine.sv - N-reel slot game core: reel counters, per-reel stop, game FSM, scoring, digit scan
//
// Ports:
//   clk        clock
//   reset      asynchronous, active-high reset
//   start_key  debounced start button level, 1 = pressed
//   stop_key   debounced per-reel stop button levels, 1 = pressed
//   seg_code   display code for the currently scanned digit (registered)
//   digit_n    active-low one-hot digit select
//   reel_val   packed reel values, reel i at [i*SYM_W +: SYM_W]
//   state      0 IDLE, 1 SPIN, 2 RESULT
//   win        1 while in RESULT after an all-equal outcome
//   score      saturating count of wins
module slot_reel_engine #(
  parameter int N_REELS      = 4,
  parameter int SYM_W        = 4,
  parameter int SYM_MAX      = 15,
  parameter int SPIN_W       = 24,
  parameter int SCAN_W       = 10,
  parameter int HOLD_STROBES = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start_key,
  input  logic [N_REELS-1:0]         stop_key,
  output logic [SYM_W:0]             seg_code,
  output logic [N_REELS-1:0]         digit_n,
  output logic [N_REELS*SYM_W-1:0]   reel_val,
  output logic [1:0]                 state,
  output logic                       win,
  output logic [7:0]                 score
);

  localparam int IDX_W  = $clog2(N_REELS);
  localparam int HOLD_W = $clog2(HOLD_STROBES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SPIN   = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  logic [SPIN_W-1:0]              spin_cnt;
  logic [SCAN_W-1:0]              scan_cnt;
  logic                           spin_stb, scan_stb;
  logic                           start_s, start_p;
  logic [N_REELS-1:0]             stop_s, stop_p;
  logic                           start_edge;
  logic [N_REELS-1:0]             stop_edge;
  logic [N_REELS-1:0][SYM_W-1:0]  reel_q;
  logic [N_REELS-1:0]             run_q;
  logic [HOLD_W-1:0]              hold_q;
  logic [IDX_W-1:0]               dig_idx;
  logic                           all_equal, hold_done;
  logic [SYM_W:0]                 seg_d;
  logic [SYM_W-1:0]               letter;
  logic [31:0]                    k;

  assign spin_stb   = &spin_cnt;
  assign scan_stb   = &scan_cnt;
  assign start_edge = start_s & ~start_p;
  assign stop_edge  = stop_s & ~stop_p;
  assign hold_done  = spin_stb && (hold_q == HOLD_W'(HOLD_STROBES - 1));
  assign reel_val   = reel_q;
  assign state      = state_q;

  always_comb begin
    all_equal = 1'b1;
    for (int i = 1; i < N_REELS; i++) begin
      if (reel_q[i] != reel_q[0]) all_equal = 1'b0;
    end
  end

  // Strobes, key sampling and the display scan run in every state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spin_cnt <= '0;
      scan_cnt <= '0;
      start_s  <= 1'b0;
      start_p  <= 1'b0;
      stop_s   <= '0;
      stop_p   <= '0;
      digit_n  <= ~N_REELS'(1);
      dig_idx  <= '0;
      seg_code <= '0;
    end else begin
      spin_cnt <= spin_cnt + 1'b1;
      scan_cnt <= scan_cnt + 1'b1;
      start_s  <= start_key;
      start_p  <= start_s;
      stop_s   <= stop_key;
      stop_p   <= stop_s;
      seg_code <= seg_d;
      if (scan_stb) begin
        digit_n <= {digit_n[N_REELS-2:0], digit_n[N_REELS-1]};
        dig_idx <= (dig_idx == IDX_W'(N_REELS - 1)) ? '0 : dig_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_edge) state_d = SPIN;
      SPIN:    if (run_q == '0) state_d = RESULT;
      RESULT: begin
        // A fresh start takes priority over the hold timing out.
        if (start_edge)     state_d = SPIN;
        else if (hold_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reel_q <= '0;
      run_q  <= '0;
      hold_q <= '0;
      win    <= 1'b0;
      score  <= '0;
    end else begin
      case (state_q)
        IDLE, RESULT: begin
          if (start_edge) begin
            reel_q <= '0;
            run_q  <= '1;
            win    <= 1'b0;
          end else if (state_q == RESULT && spin_stb) begin
            if (hold_done) win <= 1'b0;
            else           hold_q <= hold_q + 1'b1;
          end
        end
        SPIN: begin
          // A stop edge beats a coincident spin strobe on the same reel.
          for (int i = 0; i < N_REELS; i++) begin
            if (stop_edge[i])
              run_q[i] <= 1'b0;
            else if (spin_stb && run_q[i])
              reel_q[i] <= (reel_q[i] == SYM_W'(SYM_MAX)) ? '0 : reel_q[i] + 1'b1;
          end
          if (run_q == '0) begin
            win    <= all_equal;
            hold_q <= '0;
            if (all_equal && score != 8'hFF) score <= score + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Message letters: G=0 O=1 D=2 L=3 S=4 E=5.
  always_comb begin
    k = 32'(dig_idx);
    letter = '0;
    case (k)
      0:       letter = win ? SYM_W'(0) : SYM_W'(3);
      1:       letter = SYM_W'(1);
      2:       letter = win ? SYM_W'(1) : SYM_W'(4);
      3:       letter = win ? SYM_W'(2) : SYM_W'(5);
      default: letter = '0;
    endcase
    if (state_q != RESULT) seg_d = {1'b0, reel_q[dig_idx]};
    else if (k >= 32'd4)   seg_d = '1;
    else                   seg_d = {1'b1, letter};
  end

endmodule

// File: tb/tb_slot_reel_engine.sv
// tb/tb_slot_reel_engine.sv - self-checking bench for slot_reel_engine against a cycle reference model
module tb_slot_reel_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_key;
  logic [3:0]  stop_key;
  logic [4:0]  seg_code;
  logic [3:0]  digit_n;
  logic [15:0] reel_val;
  logic [1:0]  state;
  logic        win;
  logic [7:0]  score;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  slot_reel_engine #(
    .N_REELS(4), .SYM_W(4), .SYM_MAX(5), .SPIN_W(2), .SCAN_W(1), .HOLD_STROBES(2)
  ) dut (
    .clk(clk), .reset(reset), .start_key(start_key), .stop_key(stop_key),
    .seg_code(seg_code), .digit_n(digit_n), .reel_val(reel_val),
    .state(state), .win(win), .score(score)
  );

  // Reference model: m_cnt counts clock edges since reset, so spin strobes
  // fall on edges where m_cnt mod 4 == 3 and scan strobes where m_cnt is odd.
  int         m_cnt, m_state, m_hold, m_score, m_dig;
  int         m_reel[4];
  bit         m_win;
  bit  [3:0]  m_run;
  bit         m_ss, m_sp;
  bit  [3:0]  m_ks, m_kp;
  logic [4:0] m_seg;
  int         win_msg[4]  = '{16, 17, 17, 18};
  int         lose_msg[4] = '{19, 17, 20, 21};

  task automatic model_reset();
    m_cnt = 0; m_state = 0; m_hold = 0; m_score = 0; m_dig = 0;
    for (int i = 0; i < 4; i++) m_reel[i] = 0;
    m_win = 0; m_run = 0; m_ss = 0; m_sp = 0; m_ks = 0; m_kp = 0; m_seg = 0;
  endtask

  task automatic model_step();
    bit       spin_stb, scan_stb, st_e, eq;
    bit [3:0] sp_e;
    int       n_state;
    spin_stb = (m_cnt % 4) == 3;
    scan_stb = (m_cnt % 2) == 1;
    st_e     = m_ss && !m_sp;
    sp_e     = m_ks & ~m_kp;
    if (m_state != 2) m_seg = {1'b0, 4'(m_reel[m_dig])};
    else              m_seg = 5'(m_win ? win_msg[m_dig] : lose_msg[m_dig]);
    n_state = m_state;
    if ((m_state == 0 || m_state == 2) && st_e) begin
      for (int i = 0; i < 4; i++) m_reel[i] = 0;
      m_run = 4'hF; m_win = 0; n_state = 1;
    end else if (m_state == 1) begin
      if (m_run == 0) begin
        eq = (m_reel[0] == m_reel[1]) && (m_reel[1] == m_reel[2]) && (m_reel[2] == m_reel[3]);
        m_win = eq;
        if (eq && m_score < 255) m_score++;
        m_hold = 0;
        n_state = 2;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (sp_e[i]) m_run[i] = 0;
          else if (spin_stb && m_run[i]) m_reel[i] = (m_reel[i] + 1) % 6;
        end
      end
    end else if (m_state == 2 && spin_stb) begin
      m_hold++;
      if (m_hold == 2) begin n_state = 0; m_win = 0; end
    end
    m_state = n_state;
    m_cnt++;
    if (scan_stb) m_dig = (m_dig + 1) % 4;
    m_sp = m_ss; m_ss = start_key;
    m_kp = m_ks; m_ks = stop_key;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [15:0] rv;
    logic [3:0]  dn;
    for (int i = 0; i < 4; i++) rv[i*4 +: 4] = 4'(m_reel[i]);
    dn = 4'b0001;
    dn = ~(dn << m_dig);
    check("state",    32'(state),    32'(m_state));
    check("win",      32'(win),      32'(m_win));
    check("score",    32'(score),    32'(m_score));
    check("reel_val", 32'(reel_val), 32'(rv));
    check("digit_n",  32'(digit_n),  32'(dn));
    check("seg_code", 32'(seg_code), 32'(m_seg));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic wait_state(input int target, input int limit);
    int n = 0;
    while (m_state != target && n < limit) begin tick(); n++; end
    check("wait_state", 32'(state), 32'(target));
  endtask

  task automatic press_start();
    start_key = 1'b1; tick();
    start_key = 1'b0; tick();
  endtask

  // Aligns the start so that the stop edge lands on the first spin strobe.
  task automatic force_win();
    while (m_cnt % 4 != 0) tick();
    press_start();
    stop_key = 4'hF; tick();
    stop_key = 4'h0; tick();
    tick();
  endtask

  int saved_score;

  initial begin
    reset = 1'b1; start_key = 1'b0; stop_key = 4'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_state",   32'(state),    32'd0);
    check("rst_digit_n", 32'(digit_n),  32'hE);
    check("rst_seg",     32'(seg_code), 32'd0);
    check("rst_reels",   32'(reel_val), 32'd0);
    check("rst_score",   32'(score),    32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) tick();

    // Free spin for well over 10 strobes, then stop reels one at a time.
    press_start();
    repeat (44) tick();
    check("spin_state", 32'(state), 32'd1);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(1, 9)) tick();
      stop_key[i] = 1'b1; tick();
      stop_key[i] = 1'b0;
    end
    tick(); tick();
    check("result_state", 32'(state), 32'd2);
    repeat (8) tick();
    wait_state(0, 40);

    // Forced win: stop beats strobe, then hold expiry back to IDLE.
    saved_score = m_score;
    force_win();
    check("win_state", 32'(state),    32'd2);
    check("win_flag",  32'(win),      32'd1);
    check("win_reels", 32'(reel_val), 32'd0);
    check("win_score", 32'(score),    32'(saved_score + 1));
    repeat (8) tick();
    wait_state(0, 40);
    check("hold_reels", 32'(reel_val), 32'd0);
    check("hold_win",   32'(win),      32'd0);

    // Held stop key through start, re-press later; second start ignored.
    stop_key = 4'b0100; repeat (2) tick();
    press_start();
    repeat ($urandom_range(3, 10)) tick();
    stop_key = 4'b0000; repeat (2) tick();
    press_start();
    check("start_in_spin", 32'(state), 32'd1);
    repeat ($urandom_range(2, 12)) tick();
    stop_key = 4'b0100; tick();
    stop_key = 4'b0000; repeat ($urandom_range(2, 12)) tick();
    stop_key = 4'b1011; tick();
    stop_key = 4'b0000;
    wait_state(2, 10);
    repeat (8) tick();

    // Start edge inside RESULT before the hold expires.
    force_win();
    saved_score = m_score;
    press_start();
    check("restart_state", 32'(state),    32'd1);
    check("restart_reels", 32'(reel_val), 32'd0);
    check("restart_win",   32'(win),      32'd0);
    check("restart_score", 32'(score),    32'(saved_score));
    repeat ($urandom_range(1, 20)) tick();
    stop_key = 4'hF; tick();
    stop_key = 4'h0;
    wait_state(2, 10);

    // Score saturation.
    repeat (256) force_win();
    check("score_sat", 32'(score), 32'd255);

    // Asynchronous reset in the middle of a spin.
    press_start();
    repeat (6) tick();
    #2 reset = 1'b1;
    #1;
    check("arst_state",   32'(state),    32'd0);
    check("arst_digit_n", 32'(digit_n),  32'hE);
    check("arst_seg",     32'(seg_code), 32'd0);
    check("arst_reels",   32'(reel_val), 32'd0);
    check("arst_score",   32'(score),    32'd0);
    check("arst_win",     32'(win),      32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (6) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
